mode_controller: RTL and testbench

MODE_CONTROLLER -- requirements
Module: mode_controller

---
 rtl/clock_pkg.sv | 32 +++
 rtl/ack_timer.sv | 32 +++
 rtl/mode_controller.sv | 148 ++++++++++++++
 tb/tb_mode_controller.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - mode encodings, FSM state type and defaults shared by the mode controller.
package clock_pkg;

  localparam logic [1:0] MODE_CLOCK     = 2'd0;
  localparam logic [1:0] MODE_ALARM     = 2'd1;
  localparam logic [1:0] MODE_STOPWATCH = 2'd2;

  localparam int DEFAULT_ACK_TIMEOUT = 15;

  typedef enum logic [1:0] {
    ST_ACTIVE  = 2'd0,
    ST_PENDING = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  function automatic logic [1:0] next_mode(input logic [1:0] mode);
    return (mode == MODE_STOPWATCH) ? MODE_CLOCK : mode + 2'd1;
  endfunction

  // Enable vector order is {stop_watch, alarm, clock}.
  function automatic logic [2:0] mode_onehot(input logic [1:0] mode);
    logic [2:0] grant;
    case (mode)
      MODE_CLOCK:     grant = 3'b001;
      MODE_ALARM:     grant = 3'b010;
      MODE_STOPWATCH: grant = 3'b100;
      default:        grant = 3'b000;
    endcase
    return grant;
  endfunction

endpackage

// File: rtl/ack_timer.sv
// rtl/ack_timer.sv - saturating wait counter; done flags the enabled cycle whose increment reaches LIMIT.
module ack_timer #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic done
);

  localparam int W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
  localparam logic [W-1:0] LIMIT_W = W'(LIMIT);
  localparam logic [W:0]   LIMIT_X = (W+1)'(LIMIT);

  logic [W-1:0] count;
  logic [W:0]   count_inc;
  logic         saturated;

  assign count_inc = {1'b0, count} + {{W{1'b0}}, 1'b1};
  assign saturated = (count == LIMIT_W);
  assign done      = enable && (count_inc >= LIMIT_X);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && !saturated) begin
      count <= count_inc[W-1:0];
    end
  end

endmodule

// File: rtl/mode_controller.sv
// rtl/mode_controller.sv - grants one of clock/alarm/stop_watch at a time and mirrors its display fields.
module mode_controller
  import clock_pkg::*;
#(
  parameter int ACK_TIMEOUT = DEFAULT_ACK_TIMEOUT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sel_button,
  input  logic       clock_ack,
  input  logic       alarm_ack,
  input  logic       stop_watch_ack_flag,
  input  logic [5:0] clock_hi,
  input  logic [5:0] clock_lo,
  input  logic [5:0] alarm_hi,
  input  logic [5:0] alarm_lo,
  input  logic [5:0] sw_minutes,
  input  logic [5:0] sw_seconds,
  output logic       clock_en,
  output logic       alarm_en,
  output logic       stop_watch_en,
  output logic [5:0] disp_hi,
  output logic [5:0] disp_lo,
  output logic [1:0] active_mode,
  output logic       timeout_flag
);

  state_t     state_q, state_d;
  logic [1:0] mode_q, mode_d;
  logic [2:0] en_q, en_d;
  logic [5:0] hi_q, hi_d;
  logic [5:0] lo_q, lo_d;
  logic       flag_q, flag_d;

  logic       active_ack;
  logic [5:0] field_hi;
  logic [5:0] field_lo;
  logic       timer_done;

  ack_timer #(
    .LIMIT (ACK_TIMEOUT)
  ) u_ack_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (state_q == ST_ACTIVE),
    .enable (state_q == ST_PENDING),
    .done   (timer_done)
  );

  always_comb begin
    active_ack = 1'b0;
    field_hi   = 6'd0;
    field_lo   = 6'd0;
    case (mode_q)
      MODE_CLOCK: begin
        active_ack = clock_ack;
        field_hi   = clock_hi;
        field_lo   = clock_lo;
      end
      MODE_ALARM: begin
        active_ack = alarm_ack;
        field_hi   = alarm_hi;
        field_lo   = alarm_lo;
      end
      MODE_STOPWATCH: begin
        active_ack = stop_watch_ack_flag;
        field_hi   = sw_minutes;
        field_lo   = sw_seconds;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    en_d    = en_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    flag_d  = 1'b0;
    case (state_q)
      ST_ACTIVE: begin
        en_d = mode_onehot(mode_q);
        // The display follows the client only once its grant is already visible.
        if (|en_q) begin
          hi_d = field_hi;
          lo_d = field_lo;
        end
        if (sel_button) begin
          if (active_ack) begin
            state_d = ST_RELEASE;
            en_d    = 3'b000;
          end else begin
            state_d = ST_PENDING;
          end
        end
      end
      ST_PENDING: begin
        hi_d = field_hi;
        lo_d = field_lo;
        if (active_ack) begin
          state_d = ST_RELEASE;
          en_d    = 3'b000;
        end else if (timer_done) begin
          state_d = ST_RELEASE;
          en_d    = 3'b000;
          flag_d  = 1'b1;
        end
      end
      ST_RELEASE: begin
        mode_d  = next_mode(mode_q);
        en_d    = mode_onehot(mode_d);
        state_d = ST_ACTIVE;
      end
      default: begin
        state_d = ST_ACTIVE;
        en_d    = 3'b000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ACTIVE;
      mode_q  <= MODE_CLOCK;
      en_q    <= 3'b000;
      hi_q    <= 6'd0;
      lo_q    <= 6'd0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      en_q    <= en_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      flag_q  <= flag_d;
    end
  end

  assign clock_en      = en_q[0];
  assign alarm_en      = en_q[1];
  assign stop_watch_en = en_q[2];
  assign disp_hi       = hi_q;
  assign disp_lo       = lo_q;
  assign active_mode   = mode_q;
  assign timeout_flag  = flag_q;

endmodule

// File: tb/tb_mode_controller.sv
// tb/tb_mode_controller.sv - directed vector table plus multi-cycle sequences for mode_controller.
module tb_mode_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       sel_button;
  logic       clock_ack;
  logic       alarm_ack;
  logic       stop_watch_ack_flag;
  logic [5:0] clock_hi   = 6'd12;
  logic [5:0] clock_lo   = 6'd34;
  logic [5:0] alarm_hi   = 6'd1;
  logic [5:0] alarm_lo   = 6'd2;
  logic [5:0] sw_minutes = 6'd5;
  logic [5:0] sw_seconds = 6'd6;
  logic       clock_en;
  logic       alarm_en;
  logic       stop_watch_en;
  logic [5:0] disp_hi;
  logic [5:0] disp_lo;
  logic [1:0] active_mode;
  logic       timeout_flag;

  int n_checks = 0;
  int n_fail   = 0;

  mode_controller #(
    .ACK_TIMEOUT (15)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .sel_button          (sel_button),
    .clock_ack           (clock_ack),
    .alarm_ack           (alarm_ack),
    .stop_watch_ack_flag (stop_watch_ack_flag),
    .clock_hi            (clock_hi),
    .clock_lo            (clock_lo),
    .alarm_hi            (alarm_hi),
    .alarm_lo            (alarm_lo),
    .sw_minutes          (sw_minutes),
    .sw_seconds          (sw_seconds),
    .clock_en            (clock_en),
    .alarm_en            (alarm_en),
    .stop_watch_en       (stop_watch_en),
    .disp_hi             (disp_hi),
    .disp_lo             (disp_lo),
    .active_mode         (active_mode),
    .timeout_flag        (timeout_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       sel;
    logic       cack;
    logic       aack;
    logic       sack;
    logic [2:0] exp_en;
    logic [1:0] exp_mode;
    logic [5:0] exp_hi;
    logic [5:0] exp_lo;
    logic       exp_flag;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [2:0] en_vec();
    return {stop_watch_en, alarm_en, clock_en};
  endfunction

  initial begin
    int n;
    int flag_seen;

    // Cycle-by-cycle: reset, power-up grant, then three immediate switches back to clock.
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 3'b000, 2'd0, 6'd0,  6'd0,  1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 3'b000, 2'd0, 6'd0,  6'd0,  1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'b001, 2'd0, 6'd0,  6'd0,  1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'b001, 2'd0, 6'd12, 6'd34, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3'b000, 2'd0, 6'd12, 6'd34, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'b010, 2'd1, 6'd12, 6'd34, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'b010, 2'd1, 6'd1,  6'd2,  1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3'b000, 2'd1, 6'd1,  6'd2,  1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'b100, 2'd2, 6'd1,  6'd2,  1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'b100, 2'd2, 6'd5,  6'd6,  1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3'b000, 2'd2, 6'd5,  6'd6,  1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'b001, 2'd0, 6'd5,  6'd6,  1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'b001, 2'd0, 6'd12, 6'd34, 1'b0};

    for (int i = 0; i < 13; i++) begin
      rst                 = vecs[i].rst;
      sel_button          = vecs[i].sel;
      clock_ack           = vecs[i].cack;
      alarm_ack           = vecs[i].aack;
      stop_watch_ack_flag = vecs[i].sack;
      step();
      check($sformatf("vec%0d_en", i),   32'(en_vec()),       32'(vecs[i].exp_en));
      check($sformatf("vec%0d_mode", i), 32'(active_mode),    32'(vecs[i].exp_mode));
      check($sformatf("vec%0d_disp", i), 32'({disp_hi, disp_lo}), 32'({vecs[i].exp_hi, vecs[i].exp_lo}));
      check($sformatf("vec%0d_flag", i), 32'(timeout_flag),   32'(vecs[i].exp_flag));
    end

    // Deferred switch: walk to stop_watch, then ack arrives 5 cycles into PENDING.
    sel_button = 1'b1; step(); sel_button = 1'b0; step();
    sel_button = 1'b1; step(); sel_button = 1'b0; step();
    check("defer_start_mode", 32'(active_mode), 32'd2);
    stop_watch_ack_flag = 1'b0;
    sel_button = 1'b1; step(); sel_button = 1'b0;
    check("defer_p0_en", 32'(en_vec()), 32'(3'b100));
    for (int k = 1; k <= 4; k++) begin
      step();
      check($sformatf("defer_p%0d_en", k), 32'(en_vec()), 32'(3'b100));
      check($sformatf("defer_p%0d_flag", k), 32'(timeout_flag), 32'd0);
    end
    stop_watch_ack_flag = 1'b1;
    step();
    check("defer_release_en", 32'(en_vec()), 32'(3'b000));
    check("defer_release_flag", 32'(timeout_flag), 32'd0);
    step();
    check("defer_new_en", 32'(en_vec()), 32'(3'b001));
    check("defer_new_mode", 32'(active_mode), 32'd0);
    check("defer_new_flag", 32'(timeout_flag), 32'd0);

    // Timeout: alarm never acks, release forced after 15 PENDING cycles.
    sel_button = 1'b1; step(); sel_button = 1'b0; step();
    check("tmo_start_mode", 32'(active_mode), 32'd1);
    alarm_ack = 1'b0;
    sel_button = 1'b1; step(); sel_button = 1'b0;
    n = 0;
    do begin
      step();
      n++;
      if (!timeout_flag && n < 40)
        check($sformatf("tmo_hold%0d_en", n), 32'(en_vec()), 32'(3'b010));
    end while (!timeout_flag && n < 40);
    check("tmo_cycles", 32'(n), 32'd15);
    check("tmo_release_en", 32'(en_vec()), 32'(3'b000));
    step();
    check("tmo_flag_clear", 32'(timeout_flag), 32'd0);
    check("tmo_new_en", 32'(en_vec()), 32'(3'b100));
    check("tmo_new_mode", 32'(active_mode), 32'd2);

    // Presses held through PENDING and RELEASE must step only once.
    stop_watch_ack_flag = 1'b0;
    sel_button = 1'b1;
    for (int k = 0; k < 4; k++) step();
    check("ign_pending_en", 32'(en_vec()), 32'(3'b100));
    stop_watch_ack_flag = 1'b1;
    step();
    check("ign_release_en", 32'(en_vec()), 32'(3'b000));
    step();
    sel_button = 1'b0;
    check("ign_mode", 32'(active_mode), 32'd0);
    check("ign_en", 32'(en_vec()), 32'(3'b001));
    step();
    check("ign_mode_stable", 32'(active_mode), 32'd0);
    check("ign_en_stable", 32'(en_vec()), 32'(3'b001));

    // Reset 3 cycles into PENDING discards the request.
    clock_ack = 1'b0;
    sel_button = 1'b1; step(); sel_button = 1'b0;
    for (int k = 0; k < 3; k++) step();
    check("rstp_pending_en", 32'(en_vec()), 32'(3'b001));
    rst = 1'b1; step();
    check("rstp_reset_en", 32'(en_vec()), 32'(3'b000));
    check("rstp_reset_mode", 32'(active_mode), 32'd0);
    check("rstp_reset_disp", 32'({disp_hi, disp_lo}), 32'd0);
    rst = 1'b0; step();
    check("rstp_after_en", 32'(en_vec()), 32'(3'b001));
    check("rstp_after_mode", 32'(active_mode), 32'd0);
    flag_seen = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (timeout_flag) flag_seen++;
    end
    check("rstp_no_timeout", 32'(flag_seen), 32'd0);
    check("rstp_final_en", 32'(en_vec()), 32'(3'b001));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
